// File: rtl/div_result_reconstructor.sv
// div_result_reconstructor: rebuilds n_rec = q*d + r by shift-and-add, one quotient bit per cycle.
// Optional DIV_RECON_REF_CHECK_EN adds n_ref input and err_abs/mismatch outputs.
module div_result_reconstructor #(
  parameter int QW = 8,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q,
  input  logic [QW-1:0] d,
  input  logic [QW-1:0] r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] n_rec,
`ifdef DIV_RECON_REF_CHECK_EN
  input  logic [NW-1:0] n_ref,
  output logic [NW-1:0] err_abs,
  output logic          mismatch,
`endif
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state;
  logic [2:0]      r_cnt;
  logic [QW-1:0]   r_q, r_d;
  logic [NW-1:0]   r_acc, r_n;
  logic            r_in_ready, r_out_valid;
  logic [NW-1:0]   w_sum;
  always_comb w_sum = r_acc + (r_q[r_cnt] ? ({{(NW-QW){1'b0}}, r_d} << r_cnt) : '0);
`ifdef DIV_RECON_REF_CHECK_EN
  logic [NW-1:0] r_nref, r_err;
  logic          r_mis;
  always_ff @(posedge clk)
    if (rst) begin
      r_nref <= '0;
      r_err  <= '0;
      r_mis  <= 1'b0;
    end else if (r_state == IDLE && in_valid) r_nref <= n_ref;
    else if (r_state == RUN && r_cnt == 3'd7) begin
      r_err <= (w_sum >= r_nref) ? w_sum - r_nref : r_nref - w_sum;
      r_mis <= w_sum != r_nref;
    end
  assign err_abs  = r_err;
  assign mismatch = r_mis;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_acc       <= '0;
      r_n         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else case (r_state)
      IDLE: if (in_valid) begin
        r_q        <= q;
        r_d        <= d;
        r_acc      <= {{(NW-QW){1'b0}}, r};
        r_cnt      <= '0;
        r_in_ready <= 1'b0;
        r_state    <= RUN;
      end
      RUN: begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_n         <= w_sum;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
      end
      DONE: if (out_ready) begin
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_state     <= IDLE;
      end
      default: r_state <= IDLE;
    endcase
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign n_rec     = r_n;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_div_result_reconstructor.sv
// tb_div_result_reconstructor: directed checks of latency, results, DONE hold, back-to-back and reset.
module tb_div_result_reconstructor;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] q = '0, d = '0, r = '0;
  logic in_ready, out_valid, busy;
  logic [15:0] n_rec;
  int checks = 0, errors = 0;
`ifdef DIV_RECON_REF_CHECK_EN
  logic [15:0] n_ref = '0, err_abs;
  logic mismatch;
`endif
  always #5 clk = ~clk;
  div_result_reconstructor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .d(d), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .n_rec(n_rec),
`ifdef DIV_RECON_REF_CHECK_EN
    .n_ref(n_ref), .err_abs(err_abs), .mismatch(mismatch),
`endif
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [7:0] tq, input logic [7:0] td, input logic [7:0] tr, input logic [15:0] tref);
    @(negedge clk);
    q = tq; d = td; r = tr; in_valid = 1'b1;
`ifdef DIV_RECON_REF_CHECK_EN
    n_ref = tref;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    q = ~tq; d = ~td; r = ~tr;
    chk("accept_in_ready", in_ready, 0);
  endtask
  task automatic wait_done(input string tag, input logic [15:0] exp, input logic [15:0] exp_err);
    int n = 0;
    bit rdy_seen = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (in_ready) rdy_seen = 1;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_ready_low"}, rdy_seen, 0);
    chk({tag, "_n_rec"}, n_rec, exp);
`ifdef DIV_RECON_REF_CHECK_EN
    chk({tag, "_err_abs"}, err_abs, exp_err);
    chk({tag, "_mismatch"}, mismatch, exp_err != 0);
`endif
  endtask
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, out_valid, 0);
    chk({tag, "_hs_in_ready"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_n_rec", n_rec, 0);
    rst = 1'b0;
    start(8'h12, 8'h0A, 8'h04, 16'h00BC);
    chk("run_busy", busy, 1);
    wait_done("t1", 16'h00B8, 16'h0004);
    handshake("t1");
    start(8'h12, 8'h0A, 8'h04, 16'h00B8);
    wait_done("t1b", 16'h00B8, 16'h0000);
    handshake("t1b");
    start(8'hFF, 8'hFF, 8'hFF, 16'hFF00);
    wait_done("ff", 16'hFF00, 16'h0000);
    handshake("ff");
    start(8'h00, 8'h37, 8'h05, 16'h0005);
    wait_done("q0", 16'h0005, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      q = 8'hAA; d = 8'h55; r = 8'h11;
      @(posedge clk);
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_n_rec", n_rec, 16'h0005);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake("hold");
    @(negedge clk);
    chk("hold_ignored_idle", in_ready, 1);
    chk("hold_n_rec_kept", n_rec, 16'h0005);
    @(negedge clk);
    q = 8'h03; d = 8'h05; r = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
`ifdef DIV_RECON_REF_CHECK_EN
    n_ref = 16'h0010;
`endif
    @(posedge clk);
    @(negedge clk);
    q = 8'h20; d = 8'h10; r = 8'h07;
`ifdef DIV_RECON_REF_CHECK_EN
    n_ref = 16'h0207;
`endif
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      chk("b2b_a_latency", n, 8);
      chk("b2b_a_n_rec", n_rec, 16'h0010);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_gap_in_ready", in_ready, 1);
      chk("b2b_gap_out_valid", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_b_accepted", in_ready, 0);
    end
    wait_done("b2b_b", 16'h0207, 16'h0000);
    handshake("b2b_b");
    start(8'h12, 8'h0A, 8'h04, 16'h00B8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_n_rec", n_rec, 0);
    chk("mid_rst_busy", busy, 0);
    start(8'h07, 8'h09, 8'h02, 16'h0040);
    wait_done("post_rst", 16'h0041, 16'h0001);
    handshake("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
